// File: rtl/ex_div.sv
// Iterative 32-bit divider for the EX stage: DIV/DIVU/REM/REMU using one restoring
// shift-subtract step per cycle, with sign fix-up, divide-by-zero and flush handling.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic [2:0]  op_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        start_i,
    input  logic        flush_i,
    output logic [31:0] result_o,
    output logic        ready_o,
    output logic        busy_o,
    output logic [4:0]  reg_waddr_o
);

    localparam logic [2:0] OpDiv  = 3'b100;
    localparam logic [2:0] OpDivu = 3'b101;
    localparam logic [2:0] OpRem  = 3'b110;
    localparam logic [2:0] OpRemu = 3'b111;

    typedef enum logic [1:0] {StIdle, StCalc, StEnd} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] result_q, result_d;
    logic        ready_q, ready_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;

    logic        op_signed;
    logic        dividend_neg;
    logic        divisor_neg;
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] step_quot;
    logic [31:0] step_rem;
    logic [31:0] quot_fixed;
    logic [31:0] rem_fixed;
    logic        is_rem;
    logic [31:0] final_result;
    logic [31:0] zero_result;

    always_comb begin
        op_signed    = (op_i == OpDiv) || (op_i == OpRem);
        dividend_neg = op_signed & dividend_i[31];
        divisor_neg  = op_signed & divisor_i[31];
        // 0x80000000 negates to itself, which is 2^31 read as unsigned.
        dividend_abs = dividend_neg ? (~dividend_i + 32'd1) : dividend_i;
        divisor_abs  = divisor_neg ? (~divisor_i + 32'd1) : divisor_i;
    end

    // One restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        trial     = {rem_q, quot_q[31]};
        diff      = trial - {1'b0, divisor_q};
        fits      = ~diff[32];
        step_rem  = fits ? diff[31:0] : trial[31:0];
        step_quot = {quot_q[30:0], fits};
    end

    always_comb begin
        is_rem       = (op_q == OpRem) || (op_q == OpRemu);
        quot_fixed   = neg_quot_q ? (~step_quot + 32'd1) : step_quot;
        rem_fixed    = neg_rem_q ? (~step_rem + 32'd1) : step_rem;
        final_result = is_rem ? rem_fixed : quot_fixed;
        zero_result  = is_rem ? dividend_q : 32'hFFFF_FFFF;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        waddr_d    = waddr_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = 32'd0;
        ready_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !flush_i) begin
                    op_d       = op_i;
                    waddr_d    = reg_waddr_i;
                    dividend_d = dividend_i;
                    divisor_d  = divisor_abs;
                    quot_d     = dividend_abs;
                    rem_d      = 32'd0;
                    cnt_d      = 5'd0;
                    neg_quot_d = (op_i == OpDiv) && (dividend_i[31] ^ divisor_i[31]);
                    neg_rem_d  = (op_i == OpRem) && dividend_i[31];
                    state_d    = (divisor_i == 32'd0) ? StEnd : StCalc;
                end
            end
            StCalc: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    quot_d = step_quot;
                    rem_d  = step_rem;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = StEnd;
                        ready_d  = 1'b1;
                        result_d = final_result;
                    end
                end
            end
            StEnd: begin
                // Divide-by-zero arrives here without a result; publish it one cycle later.
                if (flush_i || ready_q) begin
                    state_d = StIdle;
                end else begin
                    ready_d  = 1'b1;
                    result_d = zero_result;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 5'd0;
            op_q       <= 3'd0;
            waddr_q    <= 5'd0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            quot_q     <= 32'd0;
            rem_q      <= 32'd0;
            result_q   <= 32'd0;
            ready_q    <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            waddr_q    <= waddr_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    assign result_o    = result_q;
    assign ready_o     = ready_q;
    assign busy_o      = (state_q != StIdle);
    assign reg_waddr_o = ready_q ? waddr_q : 5'd0;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: vector table plus random ops through a result
// scoreboard, and hand-written flush / reset / ignored-start sequences.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [2:0]  op_in;
    logic [4:0]  waddr;
    logic        start;
    logic        flush;
    logic [31:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic [4:0]  reg_waddr_o;

    int applied = 0;
    int miscompares = 0;

    logic [36:0] sb[$];
    logic [36:0] mon_exp;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  w;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    ex_div dut (
        .clk        (clk),
        .rst        (rst),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .op_i       (op_in),
        .reg_waddr_i(waddr),
        .start_i    (start),
        .flush_i    (flush),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .reg_waddr_o(reg_waddr_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: built-in operators plus the zero-divisor and overflow rules.
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int signed sa;
        int signed sbv;
        logic ovf;
        sa  = a;
        sbv = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            3'b100:  return ovf ? a : 32'(sa / sbv);
            3'b101:  return a / b;
            3'b110:  return ovf ? 32'd0 : 32'(sa % sbv);
            default: return a % b;
        endcase
    endfunction

    // Result scoreboard: any ready pulse must match the oldest expected entry.
    always @(negedge clk) begin
        applied++;
        if (ready_o) begin
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_ready: got result %h waddr %0d, expected no pulse",
                         result_o, reg_waddr_o);
            end else begin
                mon_exp = sb.pop_front();
                if ({reg_waddr_o, result_o} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL result: got waddr %0d result %h, expected waddr %0d result %h",
                             reg_waddr_o, result_o, mon_exp[36:32], mon_exp[31:0]);
                end
            end
        end else if (result_o !== 32'd0 || reg_waddr_o !== 5'd0) begin
            miscompares++;
            $display("FAIL idle_outputs: got result %h waddr %0d, expected 0 0",
                     result_o, reg_waddr_o);
        end
    end

    // Issue one op, check busy, latency and the post-END return to idle.
    // repulse > 0 re-asserts start with other operands before that edge after acceptance.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] w, input logic [31:0] exp, input int lat,
                          input int repulse);
        int cycles;
        bit seen;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        op_in    = op;
        waddr    = w;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back({w, exp});
        check("busy_after_accept", {31'd0, busy_o}, 32'd1);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 40) begin
            if (repulse > 0 && cycles + 1 == repulse) begin
                dividend = 32'd1000;
                divisor  = 32'd1;
                op_in    = 3'b111;
                waddr    = 5'd9;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
            seen = ready_o;
        end
        check("latency", cycles, lat);
        @(posedge clk);
        #1;
        check("busy_after_end", {31'd0, busy_o}, 32'd0);
        check("ready_single_cycle", {31'd0, ready_o}, 32'd0);
    endtask

    task automatic count_ready(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) cnt++;
        end
    endtask

    initial begin
        int rdy;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst      = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        op_in    = 3'b100;
        waddr    = 5'd0;
        start    = 1'b0;
        flush    = 1'b0;

        vecs.push_back('{3'b101, 32'd100,        32'd7,        5'd5,  32'd14,         32});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,        5'd1,  32'hFFFF_FFFF,  32});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,        5'd2,  32'hFFFF_FFFD,  32});
        vecs.push_back('{3'b100, 32'd123,        32'd0,        5'd3,  32'hFFFF_FFFF,  1});
        vecs.push_back('{3'b111, 32'd123,        32'd0,        5'd4,  32'd123,        1});
        vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd6, 32'h8000_0000,  32});
        vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7, 32'd0,          32});
        vecs.push_back('{3'b101, 32'hFFFF_FFFF,  32'd1,        5'd8,  32'hFFFF_FFFF,  32});
        vecs.push_back('{3'b111, 32'd100,        32'd7,        5'd10, 32'd2,          32});
        vecs.push_back('{3'b100, 32'd7,          32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 32});
        vecs.push_back('{3'b110, 32'd7,          32'hFFFF_FFFE, 5'd12, 32'd1,         32});
        vecs.push_back('{3'b101, 32'h8000_0000,  32'd3,        5'd13, 32'h2AAA_AAAA,  32});
        vecs.push_back('{3'b111, 32'h8000_0000,  32'd3,        5'd14, 32'd2,          32});
        vecs.push_back('{3'b100, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 5'd15, 32'd14,        32});
        vecs.push_back('{3'b110, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 5'd16, 32'hFFFF_FFFE, 32});
        vecs.push_back('{3'b101, 32'd5,          32'd10,       5'd17, 32'd0,          32});
        vecs.push_back('{3'b111, 32'd5,          32'd10,       5'd18, 32'd5,          32});
        vecs.push_back('{3'b110, 32'h8000_0000,  32'd0,        5'd19, 32'h8000_0000,  1});

        #1;
        check("reset_result", result_o, 32'd0);
        check("reset_ready", {31'd0, ready_o}, 32'd0);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_waddr", {27'd0, reg_waddr_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Back-to-back: each op starts in the idle cycle right after the previous END.
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].exp, vecs[i].lat, 0);
        end

        for (int i = 0; i < 10; i++) begin
            rop = 3'(3'b100 + 3'($urandom_range(0, 3)));
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (rb == 32'd0) rb = 32'd1;
            run_op(rop, ra, rb, 5'(i + 20), ref_div(rop, ra, rb), 32, 0);
        end

        // start re-asserted mid-CALC must not disturb the latched operation.
        run_op(3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 32, 3);

        // Flush mid-CALC: back to idle, no result.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        op_in    = 3'b101;
        waddr    = 5'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("busy_before_flush", {31'd0, busy_o}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("busy_after_flush", {31'd0, busy_o}, 32'd0);
        count_ready(40, rdy);
        check("no_ready_after_flush", rdy, 0);

        // Flush and start together in idle: the request is dropped.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_beats_start", {31'd0, busy_o}, 32'd0);
        count_ready(35, rdy);
        check("no_ready_flush_start", rdy, 0);

        // Flush while in END on the divide-by-zero path.
        @(negedge clk);
        dividend = 32'd5;
        divisor  = 32'd0;
        op_in    = 3'b100;
        waddr    = 5'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b1;
        check("busy_in_end", {31'd0, busy_o}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("end_flush_busy", {31'd0, busy_o}, 32'd0);
        check("end_flush_ready", {31'd0, ready_o}, 32'd0);
        count_ready(5, rdy);
        check("no_ready_end_flush", rdy, 0);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        op_in    = 3'b101;
        waddr    = 5'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        count_ready(40, rdy);
        check("no_ready_after_reset", rdy, 0);
        run_op(3'b101, 32'd9, 32'd3, 5'd7, 32'd3, 32, 0);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
